// File: rtl/piano_draw_pkg.sv
// Shared field geometry, colour codes, pixel payload and sequencer state enum.
package piano_draw_pkg;

    localparam int unsigned X0      = 120;
    localparam int unsigned LANE_W  = 20;
    localparam int unsigned N_LANES = 4;
    localparam int unsigned TILE_H  = 40;
    localparam int unsigned Y_MAX   = 239;

    localparam int unsigned XW = 9;
    localparam int unsigned YW = 8;
    localparam int unsigned CW = 3;

    localparam logic [CW-1:0] WHITE = 3'b111;
    localparam logic [CW-1:0] BLACK = 3'b000;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        CLR_REL,
        LANE_SEL,
        FILL,
        FINISH
    } state_t;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [CW-1:0] color;
    } pixel_t;

    // Left column of a lane, kept in the pixel-bus x width.
    function automatic logic [XW-1:0] lane_left(input int unsigned x0,
                                                input int unsigned lane_w,
                                                input int unsigned lane);
        return XW'(x0 + lane * lane_w);
    endfunction

endpackage

// File: rtl/draw_sequencer_if.sv
// Pixel-write bus to the VGA adapter plus the screen-clear stage handshake and stream.
interface draw_sequencer_if;
    import piano_draw_pkg::*;

    logic          clear_go;
    logic          clear_done;
    logic [XW-1:0] clr_x;
    logic [YW-1:0] clr_y;
    logic [CW-1:0] clr_color;
    logic          clr_en;

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] color;
    logic          vga_en;

    modport master (
        output clear_go, x, y, color, vga_en,
        input  clear_done, clr_x, clr_y, clr_color, clr_en
    );

    modport slave (
        input  clear_go, x, y, color, vga_en,
        output clear_done, clr_x, clr_y, clr_color, clr_en
    );

endinterface

// File: rtl/draw_sequencer_rect_fill.sv
// Raster walker: emits one pixel per cycle over a W-wide rectangle from (x0,y0) down to row y_end.
module rect_fill
    import piano_draw_pkg::*;
#(
    parameter int unsigned W = LANE_W
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_go,
    input  logic [XW-1:0] i_x0,
    input  logic [YW-1:0] i_y0,
    input  logic [XW-1:0] i_y_end,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y,
    output logic          o_en,
    output logic          o_last
);

    logic [XW-1:0] r_x0;
    logic [XW-1:0] r_y_end;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          r_en;
    logic          r_last;

    logic [XW-1:0] w_x_last;
    logic          w_eol;
    logic [XW-1:0] w_nx;
    logic [YW-1:0] w_ny;

    // Next raster position: step right, or wrap to the left column of the next row.
    always_comb begin
        w_x_last = r_x0 + XW'(W - 1);
        w_eol    = (r_x == w_x_last);
        w_nx     = w_eol ? r_x0 : (r_x + XW'(1));
        w_ny     = w_eol ? (r_y + YW'(1)) : r_y;
    end

    // Walker registers; last flags the cycle holding the final pixel so en drops right after it.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_x0    <= '0;
            r_y_end <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_en    <= 1'b0;
            r_last  <= 1'b0;
        end else if (i_go) begin
            r_x0    <= i_x0;
            r_y_end <= i_y_end;
            r_x     <= i_x0;
            r_y     <= i_y0;
            r_en    <= 1'b1;
            r_last  <= (W == 1) && ({1'b0, i_y0} == i_y_end);
        end else if (r_en) begin
            if (r_last) begin
                r_en   <= 1'b0;
                r_last <= 1'b0;
            end else begin
                r_x    <= w_nx;
                r_y    <= w_ny;
                r_last <= (w_nx == w_x_last) && ({1'b0, w_ny} == r_y_end);
            end
        end
    end

    assign o_x    = r_x;
    assign o_y    = r_y;
    assign o_en   = r_en;
    assign o_last = r_last;

endmodule

// File: rtl/draw_sequencer.sv
// Owns the VGA pixel bus: runs the screen-clear stage, then fills one row of tiles lane by lane.
module draw_sequencer
    import piano_draw_pkg::*;
#(
    parameter int unsigned   X0         = piano_draw_pkg::X0,
    parameter int unsigned   LANE_W     = piano_draw_pkg::LANE_W,
    parameter int unsigned   N_LANES    = piano_draw_pkg::N_LANES,
    parameter int unsigned   TILE_H     = piano_draw_pkg::TILE_H,
    parameter int unsigned   Y_MAX      = piano_draw_pkg::Y_MAX,
    parameter logic [CW-1:0] TILE_COLOR = BLACK
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [N_LANES-1:0] tile_mask,
    input  logic [YW-1:0]      tile_y,
    output logic               busy,
    output logic               done,
    draw_sequencer_if.master   pix
);

    localparam int unsigned LANE_IW = $clog2(N_LANES + 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [N_LANES-1:0]   r_mask;
    logic [N_LANES-1:0]   w_mask_next;
    logic [YW-1:0]        r_tile_y;
    logic [YW-1:0]        w_tile_y_next;
    logic [LANE_IW-1:0]   r_lane;
    logic [LANE_IW-1:0]   w_lane_next;
    logic                 r_clear_go;
    logic                 w_clear_go_next;
    logic                 r_busy;
    logic                 w_busy_next;
    logic                 r_done;
    logic                 w_done_next;
    logic [CW-1:0]        r_color;
    logic [CW-1:0]        w_color_next;

    logic                 w_fill_go;
    logic [XW-1:0]        w_fill_x0;
    logic [XW-1:0]        w_y_sum;
    logic [XW-1:0]        w_y_end;
    logic [N_LANES:0]     w_mask_ext;
    logic                 w_lane_hit;
    logic [XW-1:0]        w_fill_x;
    logic [YW-1:0]        w_fill_y;
    logic                 w_fill_en;
    logic                 w_fill_last;
    pixel_t               w_pix;
    logic                 w_pix_en;

    // Lane geometry: left column and clipped bottom row, y_end one bit wider so the sum cannot wrap.
    always_comb begin
        w_fill_x0  = lane_left(X0, LANE_W, 32'(r_lane));
        w_y_sum    = {1'b0, r_tile_y} + XW'(TILE_H - 1);
        w_y_end    = (w_y_sum > XW'(Y_MAX)) ? XW'(Y_MAX) : w_y_sum;
        w_mask_ext = {1'b0, r_mask};
        w_lane_hit = w_mask_ext[r_lane];
    end

    // Sequencer next state and next values of the registered outputs.
    always_comb begin
        w_state_next    = r_state;
        w_mask_next     = r_mask;
        w_tile_y_next   = r_tile_y;
        w_lane_next     = r_lane;
        w_clear_go_next = 1'b0;
        w_busy_next     = r_busy;
        w_done_next     = 1'b0;
        w_color_next    = r_color;
        w_fill_go       = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next    = CLEAR;
                    w_mask_next     = tile_mask;
                    w_tile_y_next   = tile_y;
                    w_lane_next     = '0;
                    w_clear_go_next = 1'b1;
                    w_busy_next     = 1'b1;
                end
            end
            CLEAR: begin
                if (pix.clear_done) begin
                    w_state_next = CLR_REL;
                end else begin
                    w_clear_go_next = 1'b1;
                end
            end
            CLR_REL: begin
                w_state_next = LANE_SEL;
            end
            LANE_SEL: begin
                if (r_lane == LANE_IW'(N_LANES)) begin
                    w_state_next = FINISH;
                    w_done_next  = 1'b1;
                    w_busy_next  = 1'b0;
                end else if (w_lane_hit && (r_tile_y <= YW'(Y_MAX))) begin
                    w_state_next = FILL;
                    w_fill_go    = 1'b1;
                    w_color_next = TILE_COLOR;
                end else begin
                    w_lane_next = r_lane + LANE_IW'(1);
                end
            end
            FILL: begin
                if (w_fill_last) begin
                    w_state_next = LANE_SEL;
                    w_lane_next  = r_lane + LANE_IW'(1);
                end
            end
            FINISH: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_mask     <= '0;
            r_tile_y   <= '0;
            r_lane     <= '0;
            r_clear_go <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_color    <= '0;
        end else begin
            r_state    <= w_state_next;
            r_mask     <= w_mask_next;
            r_tile_y   <= w_tile_y_next;
            r_lane     <= w_lane_next;
            r_clear_go <= w_clear_go_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
            r_color    <= w_color_next;
        end
    end

    rect_fill #(
        .W (LANE_W)
    ) u_rect_fill (
        .clock   (clock),
        .reset   (reset),
        .i_go    (w_fill_go),
        .i_x0    (w_fill_x0),
        .i_y0    (r_tile_y),
        .i_y_end (w_y_end),
        .o_x     (w_fill_x),
        .o_y     (w_fill_y),
        .o_en    (w_fill_en),
        .o_last  (w_fill_last)
    );

    // Bus owner mux: clear stage streams straight through during CLEAR, local registers otherwise.
    always_comb begin
        if (r_state == CLEAR) begin
            w_pix.x     = pix.clr_x;
            w_pix.y     = pix.clr_y;
            w_pix.color = pix.clr_color;
            w_pix_en    = pix.clr_en;
        end else begin
            w_pix.x     = w_fill_x;
            w_pix.y     = w_fill_y;
            w_pix.color = r_color;
            w_pix_en    = w_fill_en;
        end
    end

    assign pix.x        = w_pix.x;
    assign pix.y        = w_pix.y;
    assign pix.color    = w_pix.color;
    assign pix.vga_en   = w_pix_en;
    assign pix.clear_go = r_clear_go;
    assign busy         = r_busy;
    assign done         = r_done;

endmodule

// File: tb/tb_draw_sequencer.sv
// Directed bench for draw_sequencer with a ten-cycle clear-stage model and a raster-order pixel monitor.
module tb_draw_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] tile_mask;
    logic [7:0] tile_y;
    logic       busy;
    logic       done;

    draw_sequencer_if pix();

    draw_sequencer dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .tile_mask (tile_mask),
        .tile_y    (tile_y),
        .busy      (busy),
        .done      (done),
        .pix       (pix)
    );

    always #5 clock = ~clock;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic chk(input string tag, input int unsigned act, input int unsigned exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Clear-stage model: raises done ten cycles after go, drops it once go is released.
    int unsigned clr_cnt = 0;
    always @(posedge clock) begin
        if (!pix.clear_go)      clr_cnt <= 0;
        else if (clr_cnt < 10)  clr_cnt <= clr_cnt + 1;
    end
    assign pix.clear_done = (clr_cnt == 10);
    assign pix.clr_en     = pix.clear_go;
    assign pix.clr_x      = 9'(200 + clr_cnt);
    assign pix.clr_y      = 8'(3 + clr_cnt);
    assign pix.clr_color  = 3'b111;

    // Monitor statistics and expected raster walk.
    int unsigned fill_cnt, clr_cyc, busy_nc, done_cnt, go_rise;
    int unsigned pass_err, color_err, busy_err, gap_cnt, order_err;
    int unsigned xmin, xmax, ymin, ymax;
    int unsigned exp_n, exp_y0, exp_y1, m_li, m_row, m_col;
    int unsigned exp_x0 [4];
    logic        prev_go = 1'b0;

    task automatic clr_stats();
        fill_cnt = 0; clr_cyc = 0; busy_nc = 0; done_cnt = 0; go_rise = 0;
        pass_err = 0; color_err = 0; busy_err = 0; gap_cnt = 0; order_err = 0;
        xmin = 999; xmax = 0; ymin = 999; ymax = 0;
        m_li = 0; m_row = 0; m_col = 0;
    endtask

    always @(negedge clock) begin
        if (pix.clear_go) begin
            clr_cyc++;
            if (pix.vga_en !== pix.clr_en || pix.x !== pix.clr_x ||
                pix.y !== pix.clr_y || pix.color !== pix.clr_color)
                pass_err++;
        end else begin
            if (busy) busy_nc++;
            if (pix.vga_en) begin
                fill_cnt++;
                if (pix.color !== 3'b000) color_err++;
                if (pix.x >= 9'd140 && pix.x <= 9'd159) gap_cnt++;
                if (32'(pix.x) < xmin) xmin = 32'(pix.x);
                if (32'(pix.x) > xmax) xmax = 32'(pix.x);
                if (32'(pix.y) < ymin) ymin = 32'(pix.y);
                if (32'(pix.y) > ymax) ymax = 32'(pix.y);
                if (m_li >= exp_n) begin
                    order_err++;
                end else begin
                    if (32'(pix.x) != exp_x0[m_li] + m_col || 32'(pix.y) != exp_y0 + m_row)
                        order_err++;
                    m_col++;
                    if (m_col == 20) begin
                        m_col = 0;
                        m_row++;
                        if (exp_y0 + m_row > exp_y1) begin
                            m_row = 0;
                            m_li++;
                        end
                    end
                end
            end
        end
        if (done === 1'b1) begin
            done_cnt++;
            if (busy !== 1'b0) busy_err++;
        end
        if (pix.clear_go && !prev_go) go_rise++;
        prev_go = pix.clear_go;
    end

    // One full sequence; restart_at > 0 re-pulses start once that many fill pixels have gone by.
    task automatic run(input string name, input logic [3:0] m, input int unsigned ty,
                       input int unsigned restart_at, input int unsigned exp_pix,
                       input int unsigned xlo, input int unsigned xhi,
                       input int unsigned ylo, input int unsigned yhi);
        int unsigned k;
        clr_stats();
        exp_n  = 0;
        exp_y0 = ty;
        exp_y1 = (ty + 39 > 239) ? 239 : ty + 39;
        for (int i = 0; i < 4; i++) begin
            if (m[i] && ty <= 239) begin
                exp_x0[exp_n] = 120 + 20 * i;
                exp_n++;
            end
        end
        start = 1'b1; tile_mask = m; tile_y = 8'(ty);
        tick();
        start = 1'b0; tile_mask = ~m; tile_y = 8'd5;
        @(negedge clock);
        chk({name, ".busy_on"}, 32'(busy), 1);
        chk({name, ".go_on"}, 32'(pix.clear_go), 1);
        if (restart_at > 0) begin
            k = 0;
            while (fill_cnt < restart_at && k < 5000) begin tick(); k++; end
            chk({name, ".reach_fill"}, 32'(fill_cnt >= restart_at), 1);
            start = 1'b1; tile_mask = 4'b1111; tile_y = 8'd0;
            tick();
            start = 1'b0;
        end
        k = 0;
        while (done_cnt == 0 && k < 20000) begin tick(); k++; end
        chk({name, ".timeout"}, 32'(done_cnt == 0), 0);
        repeat (5) tick();
        chk({name, ".pixels"}, fill_cnt, exp_pix);
        chk({name, ".order"}, order_err, 0);
        chk({name, ".done_cnt"}, done_cnt, 1);
        chk({name, ".go_rise"}, go_rise, 1);
        chk({name, ".clr_cycles"}, clr_cyc, 11);
        chk({name, ".passthru"}, pass_err, 0);
        chk({name, ".busy_cycles"}, busy_nc, 6 + exp_pix);
        chk({name, ".color"}, color_err, 0);
        chk({name, ".busy_at_done"}, busy_err, 0);
        chk({name, ".lane1_px"}, gap_cnt, 0);
        chk({name, ".busy_end"}, 32'(busy), 0);
        if (exp_pix > 0) begin
            chk({name, ".xmin"}, xmin, xlo);
            chk({name, ".xmax"}, xmax, xhi);
            chk({name, ".ymin"}, ymin, ylo);
            chk({name, ".ymax"}, ymax, yhi);
        end
    endtask

    // Reset mid-operation: fill_thr == 0 hits CLEAR, otherwise waits for that many fill pixels.
    task automatic rst_mid(input string name, input int unsigned fill_thr);
        int unsigned k;
        clr_stats();
        exp_n = 0;
        start = 1'b1; tile_mask = 4'b0001; tile_y = 8'd0;
        tick();
        start = 1'b0;
        if (fill_thr == 0) begin
            repeat (4) tick();
            chk({name, ".in_clear"}, 32'(pix.clear_go), 1);
        end else begin
            k = 0;
            while (fill_cnt < fill_thr && k < 5000) begin tick(); k++; end
            chk({name, ".in_fill"}, 32'(pix.vga_en), 1);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clock);
        chk({name, ".go_off"}, 32'(pix.clear_go), 0);
        chk({name, ".en_off"}, 32'(pix.vga_en), 0);
        chk({name, ".busy_off"}, 32'(busy), 0);
        chk({name, ".done_off"}, 32'(done), 0);
        repeat (3) tick();
        run({name, ".rerun"}, 4'b0001, 0, 0, 800, 120, 139, 0, 39);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; tile_mask = '0; tile_y = '0;
        clr_stats();
        exp_n = 0; exp_y0 = 0; exp_y1 = 0;
        repeat (3) tick();
        @(negedge clock);
        chk("rst.x", 32'(pix.x), 0);
        chk("rst.y", 32'(pix.y), 0);
        chk("rst.color", 32'(pix.color), 0);
        chk("rst.vga_en", 32'(pix.vga_en), 0);
        chk("rst.clear_go", 32'(pix.clear_go), 0);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.done", 32'(done), 0);
        tick();
        reset = 1'b0;
        repeat (2) tick();

        run("one_lane",  4'b0001,   0,   0,  800, 120, 139,   0,  39);
        run("clip",      4'b1000, 220,   0,  400, 180, 199, 220, 239);
        run("skip",      4'b0101, 100,   0, 1600, 120, 179, 100, 139);
        run("mask0",     4'b0000,   0,   0,    0,   0,   0,   0,   0);
        run("y_off",     4'b1111, 250,   0,    0,   0,   0,   0,   0);
        run("restart",   4'b0001,   0, 100,  800, 120, 139,   0,  39);
        rst_mid("rst_clear", 0);
        rst_mid("rst_fill", 50);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
